mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter in front of one line-wide memory port.
// Round-robin on simultaneous requests; a grant is held until resp or request withdrawal.
module mem_arbiter #(
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [15:0]           i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [15:0]           d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [15:0]           pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   last_grant_reg, last_grant_next;  // 0 = I served last, 1 = D served last
  logic   i_req, d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // Read data is shared; each client qualifies it with its own resp.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    pmem_address    = 16'h0000;
    pmem_wdata      = '0;
    i_pmem_resp     = 1'b0;
    d_pmem_resp     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_req && d_req) begin
          if (last_grant_reg) begin
            state_next      = SERVE_I;
            last_grant_next = 1'b0;
          end else begin
            state_next      = SERVE_D;
            last_grant_next = 1'b1;
          end
        end else if (i_req) begin
          state_next      = SERVE_I;
          last_grant_next = 1'b0;
        end else if (d_req) begin
          state_next      = SERVE_D;
          last_grant_next = 1'b1;
        end
      end

      SERVE_I: begin
        pmem_read    = i_pmem_read;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp & i_req;
        if (!i_req || pmem_resp)
          state_next = IDLE;
      end

      SERVE_D: begin
        // A simultaneous read+write is illegal; only the write is forwarded.
        pmem_write   = d_pmem_write;
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp & d_req;
        if (!d_req || pmem_resp)
          state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: clients and memory behave randomly, and a
// transaction-level ownership model predicts every output each cycle.
module tb_mem_arbiter;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_pmem_read;
  logic [15:0]   i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [15:0]   d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [15:0]   pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int checks = 0;
  int errors = 0;

  // Model: who owns the memory port right now (0 none, 1 I, 2 D) and who was granted last.
  int   owner;
  logic last_was_d;
  logic exp_i_resp, exp_d_resp;
  int   grants_i, grants_d;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    logic          e_rd, e_wr;
    logic [15:0]   e_addr;
    logic [LW-1:0] e_wd;
    e_rd = 1'b0; e_wr = 1'b0; e_addr = 16'h0; e_wd = '0;
    exp_i_resp = 1'b0; exp_d_resp = 1'b0;
    if (owner == 1) begin
      e_rd       = i_pmem_read;
      e_addr     = i_pmem_address;
      exp_i_resp = pmem_resp && i_pmem_read;
    end else if (owner == 2) begin
      e_wr       = d_pmem_write;
      e_rd       = d_pmem_read && !d_pmem_write;
      e_addr     = d_pmem_address;
      e_wd       = d_pmem_wdata;
      exp_d_resp = pmem_resp && (d_pmem_read || d_pmem_write);
    end
    chk({where, " pmem_read"},    LW'(pmem_read),    LW'(e_rd));
    chk({where, " pmem_write"},   LW'(pmem_write),   LW'(e_wr));
    chk({where, " pmem_address"}, LW'(pmem_address), LW'(e_addr));
    chk({where, " pmem_wdata"},   pmem_wdata,        e_wd);
    chk({where, " i_pmem_resp"},  LW'(i_pmem_resp),  LW'(exp_i_resp));
    chk({where, " d_pmem_resp"},  LW'(d_pmem_resp),  LW'(exp_d_resp));
    chk({where, " i_pmem_rdata"}, i_pmem_rdata,      pmem_rdata);
    chk({where, " d_pmem_rdata"}, d_pmem_rdata,      pmem_rdata);
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int   next_owner;
    logic i_want, d_want, prev_i_resp, prev_d_resp;
    int   k;

    reset = 1'b1;
    i_pmem_read = 0; i_pmem_address = 16'h0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = 16'h0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    owner = 0; last_was_d = 1'b0;
    exp_i_resp = 0; exp_d_resp = 0;
    grants_i = 0; grants_d = 0;

    #1 check_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      prev_i_resp = exp_i_resp;
      prev_d_resp = exp_d_resp;

      // Client I: hold request until its resp, occasionally withdraw early.
      if (i_pmem_read) begin
        if (prev_i_resp || ($urandom % 40 == 0)) i_pmem_read = 1'b0;
      end else if ($urandom % 3 == 0) begin
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'($urandom);
      end
      // Client D: reads, write-backs, and rarely the illegal read+write.
      if (d_pmem_read || d_pmem_write) begin
        if (prev_d_resp || ($urandom % 40 == 0)) begin
          d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        end
      end else if ($urandom % 3 == 0) begin
        k = int'($urandom % 16);
        d_pmem_read    = (k < 8) || (k == 15);
        d_pmem_write   = (k >= 8);
        d_pmem_address = 16'($urandom);
        d_pmem_wdata   = rand_line();
      end
      // Memory: random resp pulses, including spurious ones while idle.
      pmem_resp  = ($urandom % 4 == 0);
      pmem_rdata = rand_line();

      // Occasional asynchronous reset pulse between clock edges.
      if (cyc % 250 == 137) begin
        reset = 1'b1;
        owner = 0; last_was_d = 1'b0;
        #1 check_outputs("async_reset");
        #1 reset = 1'b0;
        #1;
      end else begin
        #3;
      end
      check_outputs("cycle");

      i_want = i_pmem_read;
      d_want = d_pmem_read || d_pmem_write;
      if (owner == 0) begin
        if (i_want && d_want) next_owner = last_was_d ? 1 : 2;
        else if (i_want)      next_owner = 1;
        else if (d_want)      next_owner = 2;
        else                  next_owner = 0;
        if (next_owner == 1) begin last_was_d = 1'b0; grants_i++; end
        if (next_owner == 2) begin last_was_d = 1'b1; grants_d++; end
      end else if (owner == 1) begin
        next_owner = (i_want && !pmem_resp) ? 1 : 0;
      end else begin
        next_owner = (d_want && !pmem_resp) ? 2 : 0;
      end

      @(posedge clk);
      owner = next_owner;
      #1;
    end

    checks++;
    assert (grants_i > 0 && grants_d > 0) else begin
      errors++;
      $error("FAIL grant_coverage: observed I=%0d D=%0d expected both nonzero", grants_i, grants_d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
